// File: rtl/int_dispatch.sv
// int_dispatch - edge-captured interrupt pending register with snapshot/settle/grant dispatch FSM
// Presents unmasked requests to a 3x9 priority controller and acknowledges the granted channel.
module int_dispatch #(
  parameter int SETTLE = 2
) (
  input  logic        CK,
  input  logic        RSTN,
  input  logic [26:0] req_in,
  input  logic [26:0] mask_in,
  input  logic        cpu_ack,
  input  logic        err_clr,
  input  logic        gnt_pa,
  input  logic        gnt_pb,
  input  logic        gnt_pc,
  input  logic [3:0]  gnt_chan,
  output logic [8:0]  pend_a,
  output logic [8:0]  pend_b,
  output logic [8:0]  pend_c,
  output logic        irq,
  output logic [4:0]  vec,
  output logic        vec_valid,
  output logic [26:0] ack_out,
  output logic        busy,
  output logic        err
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic [26:0] req_q;
  logic [26:0] pending;
  logic        armed;

  logic [26:0] rise;
  logic [26:0] vis;
  logic [26:0] snap;
  logic        one_bus;
  logic [4:0]  base;
  logic [4:0]  idx;
  logic [26:0] sel;
  logic        gnt_ok;
  logic        sample;
  logic [26:0] clr;

  // armed stays low for the first edge after reset so levels already high are not seen as edges
  always_comb begin
    rise    = armed ? (req_in & ~req_q) : '0;
    vis     = pending & ~mask_in;
    snap    = {pend_c, pend_b, pend_a};
    one_bus = (gnt_pa & ~gnt_pb & ~gnt_pc) |
              (~gnt_pa & gnt_pb & ~gnt_pc) |
              (~gnt_pa & ~gnt_pb & gnt_pc);
    base    = gnt_pa ? 5'd0 : (gnt_pb ? 5'd9 : 5'd18);
    idx     = base + {1'b0, gnt_chan};
    sel     = 27'd1 << idx;
    gnt_ok  = one_bus && (gnt_chan <= 4'd8) && (|(snap & sel));
    sample  = (state == WAIT) && (cnt == 4'd1);
    clr     = (sample && gnt_ok) ? sel : '0;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge CK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= IDLE;
      cnt       <= '0;
      req_q     <= '0;
      pending   <= '0;
      armed     <= 1'b0;
      pend_a    <= '0;
      pend_b    <= '0;
      pend_c    <= '0;
      irq       <= 1'b0;
      vec       <= '0;
      vec_valid <= 1'b0;
      ack_out   <= '0;
      err       <= 1'b0;
    end else begin
      armed     <= 1'b1;
      req_q     <= req_in;
      // a fresh edge on the channel being cleared keeps it pending
      pending   <= (pending & ~clr) | rise;
      irq       <= |vis;
      vec_valid <= 1'b0;
      ack_out   <= '0;

      case (state)
        IDLE: begin
          {pend_c, pend_b, pend_a} <= vis;
          if (cpu_ack && irq) begin
            state <= WAIT;
            cnt   <= 4'(SETTLE);
          end
        end
        WAIT: begin
          if (cnt == 4'd1) begin
            cnt   <= '0;
            state <= DONE;
            if (gnt_ok) begin
              vec       <= idx;
              vec_valid <= 1'b1;
              ack_out   <= sel;
            end
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (sample && !gnt_ok)
        err <= 1'b1;
      else if (err_clr)
        err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_int_dispatch.sv
// tb_int_dispatch - scoreboard-based bench for int_dispatch
module tb_int_dispatch;

  localparam int SETTLE = 2;

  logic        CK = 1'b0;
  logic        RSTN;
  logic [26:0] req_in;
  logic [26:0] mask_in;
  logic        cpu_ack;
  logic        err_clr;
  logic        gnt_pa, gnt_pb, gnt_pc;
  logic [3:0]  gnt_chan;
  logic [8:0]  pend_a, pend_b, pend_c;
  logic        irq;
  logic [4:0]  vec;
  logic        vec_valid;
  logic [26:0] ack_out;
  logic        busy;
  logic        err;

  int total = 0;
  int bad = 0;
  int exp_q[$];

  int_dispatch #(.SETTLE(SETTLE)) dut (
    .CK(CK), .RSTN(RSTN), .req_in(req_in), .mask_in(mask_in),
    .cpu_ack(cpu_ack), .err_clr(err_clr),
    .gnt_pa(gnt_pa), .gnt_pb(gnt_pb), .gnt_pc(gnt_pc), .gnt_chan(gnt_chan),
    .pend_a(pend_a), .pend_b(pend_b), .pend_c(pend_c), .irq(irq),
    .vec(vec), .vec_valid(vec_valid), .ack_out(ack_out), .busy(busy), .err(err)
  );

  always #5 CK = ~CK;

  task tick;
    @(posedge CK);
    @(negedge CK);
  endtask

  task pulse(input int ch);
    req_in[ch] = 1'b1;
    tick;
    req_in[ch] = 1'b0;
    tick;
  endtask

  task set_gnt(input logic a, input logic b, input logic c, input int ch);
    gnt_pa   = a;
    gnt_pb   = b;
    gnt_pc   = c;
    gnt_chan = 4'(ch);
  endtask

  task dispatch(input int bus, input int ch);
    int n;
    int e;
    logic [26:0] ea;
    set_gnt(bus == 0, bus == 1, bus == 2, ch);
    exp_q.push_back(bus * 9 + ch);
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    n = 0;
    while (!vec_valid && n < 10) begin
      tick;
      n++;
    end
    e = exp_q.pop_front();
    ea = 27'd1 << e;
    total++;
    if (vec_valid !== 1'b1) begin
      bad++;
      $display("FAIL dispatch_timeout ch=%0d vec_valid=%b required=1", e, vec_valid);
    end else begin
      total++;
      if (n !== SETTLE) begin
        bad++;
        $display("FAIL dispatch_latency ch=%0d got=%0d required=%0d", e, n, SETTLE);
      end
      total++;
      if (vec !== 5'(e) || ack_out !== ea) begin
        bad++;
        $display("FAIL dispatch_vec vec=%0d ack=%h required vec=%0d ack=%h", vec, ack_out, e, ea);
      end
    end
    tick;
    total++;
    if (vec_valid !== 1'b0 || ack_out !== 27'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL dispatch_after vv=%b ack=%h busy=%b required 0 0 0", vec_valid, ack_out, busy);
    end
    set_gnt(0, 0, 0, 0);
  endtask

  task test_reset;
    RSTN = 1'b0;
    @(negedge CK);
    @(negedge CK);
    total++;
    if ({pend_c, pend_b, pend_a, irq, vec, vec_valid, ack_out, busy, err} !== '0) begin
      bad++;
      $display("FAIL reset_state pend=%h irq=%b vec=%0d vv=%b ack=%h busy=%b err=%b required all 0",
               {pend_c, pend_b, pend_a}, irq, vec, vec_valid, ack_out, busy, err);
    end
    RSTN = 1'b1;
    tick;
  endtask

  task test_single;
    pulse(12);
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL single_irq_before irq=%b required=1", irq);
    end
    dispatch(1, 3);
    total++;
    if (irq !== 1'b0 || vec !== 5'd12) begin
      bad++;
      $display("FAIL single_after irq=%b vec=%0d required irq=0 vec=12", irq, vec);
    end
  endtask

  task test_freeze;
    int n;
    logic leak;
    int e;
    pulse(0);
    set_gnt(1, 0, 0, 0);
    exp_q.push_back(0);
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    req_in[20] = 1'b1;
    leak = 1'b0;
    n = 0;
    while (!vec_valid && n < 10) begin
      if (pend_c !== 9'h000) leak = 1'b1;
      tick;
      n++;
    end
    if (pend_c !== 9'h000) leak = 1'b1;
    e = exp_q.pop_front();
    total++;
    if (vec_valid !== 1'b1 || vec !== 5'(e)) begin
      bad++;
      $display("FAIL freeze_dispatch vv=%b vec=%0d required vv=1 vec=%0d", vec_valid, vec, e);
    end
    total++;
    if (leak !== 1'b0) begin
      bad++;
      $display("FAIL freeze_pend_c changed while frozen, pend_c=%h required=000", pend_c);
    end
    set_gnt(0, 0, 0, 0);
    tick;
    tick;
    req_in[20] = 1'b0;
    total++;
    if (pend_c !== 9'h004 || pend_a !== 9'h000) begin
      bad++;
      $display("FAIL freeze_idle pend_c=%h pend_a=%h required 004 000", pend_c, pend_a);
    end
  endtask

  task test_invalid;
    logic [4:0] tbl [4];
    logic seen;
    tbl[0] = {1'b1, 1'b0, 1'b1, 2'd0};
    tbl[1] = {1'b0, 1'b0, 1'b0, 2'd0};
    tbl[2] = {1'b0, 1'b0, 1'b1, 2'd1};
    tbl[3] = {1'b0, 1'b1, 1'b0, 2'd2};
    for (int i = 0; i < 4; i++) begin
      set_gnt(tbl[i][4], tbl[i][3], tbl[i][2],
              (tbl[i][1:0] == 2'd1) ? 9 : (tbl[i][1:0] == 2'd2) ? 4 : 2);
      cpu_ack = 1'b1;
      tick;
      cpu_ack = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < SETTLE + 2; k++) begin
        tick;
        if (vec_valid !== 1'b0 || ack_out !== 27'd0) seen = 1'b1;
      end
      total++;
      if (seen !== 1'b0 || err !== 1'b1) begin
        bad++;
        $display("FAIL invalid_%0d strobe_seen=%b err=%b required 0 1", i, seen, err);
      end
      total++;
      if (irq !== 1'b1 || pend_c !== 9'h004) begin
        bad++;
        $display("FAIL invalid_pending_%0d irq=%b pend_c=%h required 1 004", i, irq, pend_c);
      end
      err_clr = 1'b1;
      tick;
      err_clr = 1'b0;
      total++;
      if (err !== 1'b0) begin
        bad++;
        $display("FAIL invalid_clr_%0d err=%b required=0", i, err);
      end
    end
    set_gnt(1, 0, 1, 2);
    err_clr = 1'b1;
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    for (int k = 0; k < SETTLE; k++) tick;
    total++;
    if (err !== 1'b1) begin
      bad++;
      $display("FAIL err_set_wins err=%b required=1", err);
    end
    tick;
    err_clr = 1'b0;
    total++;
    if (err !== 1'b0) begin
      bad++;
      $display("FAIL err_clear_after err=%b required=0", err);
    end
    tick;
    dispatch(2, 2);
  endtask

  task test_collision;
    int e;
    pulse(5);
    set_gnt(1, 0, 0, 5);
    exp_q.push_back(5);
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    for (int k = 0; k < SETTLE - 1; k++) tick;
    req_in[5] = 1'b1;
    tick;
    e = exp_q.pop_front();
    total++;
    if (vec_valid !== 1'b1 || vec !== 5'(e) || ack_out !== 27'h20) begin
      bad++;
      $display("FAIL collision_dispatch vv=%b vec=%0d ack=%h required 1 %0d 0000020", vec_valid, vec, ack_out, e);
    end
    set_gnt(0, 0, 0, 0);
    tick;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL collision_irq irq=%b required=1", irq);
    end
    tick;
    total++;
    if (pend_a !== 9'h020) begin
      bad++;
      $display("FAIL collision_pend pend_a=%h required=020", pend_a);
    end
    req_in[5] = 1'b0;
    tick;
    dispatch(0, 5);
  endtask

  task test_mask;
    mask_in[7] = 1'b1;
    pulse(7);
    tick;
    total++;
    if (irq !== 1'b0 || pend_a !== 9'h000) begin
      bad++;
      $display("FAIL mask_irq irq=%b pend_a=%h required 0 000", irq, pend_a);
    end
    set_gnt(1, 0, 0, 7);
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    total++;
    if (busy !== 1'b0) begin
      bad++;
      $display("FAIL mask_ack_ignored busy=%b required=0", busy);
    end
    mask_in[7] = 1'b0;
    tick;
    total++;
    if (irq !== 1'b1) begin
      bad++;
      $display("FAIL mask_drop irq=%b required=1", irq);
    end
    dispatch(0, 7);
  endtask

  task test_reset_mid;
    logic seen;
    pulse(3);
    set_gnt(1, 0, 0, 3);
    cpu_ack = 1'b1;
    tick;
    cpu_ack = 1'b0;
    total++;
    if (busy !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_busy busy=%b required=1", busy);
    end
    req_in[1] = 1'b1;
    #1;
    RSTN = 1'b0;
    #1;
    total++;
    if ({pend_c, pend_b, pend_a, irq, vec, vec_valid, ack_out, busy, err} !== '0) begin
      bad++;
      $display("FAIL rstmid_async pend=%h irq=%b vec=%0d vv=%b ack=%h busy=%b err=%b required all 0",
               {pend_c, pend_b, pend_a}, irq, vec, vec_valid, ack_out, busy, err);
    end
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      if (ack_out !== 27'd0 || vec_valid !== 1'b0) seen = 1'b1;
    end
    RSTN = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick;
      if (ack_out !== 27'd0 || vec_valid !== 1'b0) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_no_ack strobe seen after reset, required none");
    end
    total++;
    if (irq !== 1'b0 || pend_a !== 9'h000) begin
      bad++;
      $display("FAIL rstmid_level irq=%b pend_a=%h required 0 000", irq, pend_a);
    end
    req_in[1] = 1'b0;
    set_gnt(0, 0, 0, 0);
    tick;
  endtask

  initial begin
    req_in   = '0;
    mask_in  = '0;
    cpu_ack  = 1'b0;
    err_clr  = 1'b0;
    set_gnt(0, 0, 0, 0);
    test_reset;
    test_single;
    test_freeze;
    test_invalid;
    test_collision;
    test_mask;
    test_reset_mid;
    total++;
    if (exp_q.size() !== 0) begin
      bad++;
      $display("FAIL scoreboard_leftover size=%0d required=0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
